change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 190 +++++++++++++++++++
 tb/tb_change_dispenser.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - coin-accepting vend controller with dime/nickel change payout
// Optional feature macro: EXACT_CHANGE_EN (adds exactChange flag and overpay rejection)
module change_dispenser #(
   parameter logic [7:0] PRICE = 8'd65
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] coin_in,
   input  logic       coin_valid,
   input  logic [7:0] nickelCount,
   input  logic [7:0] dimeCount,
   output logic       countEnable,
   output logic [1:0] coin_out,
   output logic       coinReject,
   output logic [7:0] credit,
   output logic [5:0] dispenseReady,
   output logic [7:0] subNickel,
   output logic [7:0] subDime,
   output logic       changeShort
`ifdef EXACT_CHANGE_EN
   ,
   output logic       exactChange
`endif
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_VEND   = 2'd1;
   localparam logic [1:0] ST_CHANGE = 2'd2;

   logic [1:0] r_state;
   logic [7:0] r_credit;
   logic       r_count_en;
   logic [1:0] r_coin_out;
   logic       r_reject;
   logic [5:0] r_dispense;
   logic [7:0] r_sub_nickel;
   logic [7:0] r_sub_dime;
   logic       r_short;
`ifdef EXACT_CHANGE_EN
   logic       r_exact;
   logic       w_exact_next;
   logic       w_overpay;
`endif

   logic       w_coin_present;
   logic [7:0] w_coin_value;
   logic [8:0] w_sum;
   logic       w_paid;
   logic       w_accept;
   logic       w_reject;
   logic [7:0] w_change;
   logic [7:0] w_dime_need;
   logic [7:0] w_sub_dime;
   logic [7:0] w_rem;
   logic [7:0] w_nickel_need;
   logic [7:0] w_sub_nickel;
   logic       w_short;
   logic [5:0] w_vend_code;

   assign w_coin_present = coin_valid && (coin_in != 2'b00);
   assign w_sum          = {1'b0, r_credit} + {1'b0, w_coin_value};
   assign w_paid         = (r_credit >= PRICE);
   assign w_change       = r_credit - PRICE;

   // Coin type to cents
   always_comb begin
      w_coin_value = 8'd0;
      case (coin_in)
         2'b01:   w_coin_value = 8'd5;
         2'b10:   w_coin_value = 8'd10;
         2'b11:   w_coin_value = 8'd25;
         default: w_coin_value = 8'd0;
      endcase
   end

`ifdef EXACT_CHANGE_EN
   // Inventory cannot guarantee every change amount 5..20, so overpaying is refused
   assign w_exact_next = !((nickelCount >= 8'd1) &&
                           ((dimeCount >= 8'd1) || (nickelCount >= 8'd3)) &&
                           ((dimeCount >= 8'd2) ||
                            ((dimeCount >= 8'd1) && (nickelCount >= 8'd2)) ||
                            (nickelCount >= 8'd4)));
   assign w_overpay    = r_exact && (w_sum > {1'b0, PRICE});
   assign w_accept     = (r_state == ST_IDLE) && w_coin_present && !w_paid && !w_overpay;
`else
   assign w_accept     = (r_state == ST_IDLE) && w_coin_present && !w_paid;
`endif
   assign w_reject = w_coin_present && !w_accept;

   // Change payout: dimes first, then nickels; change never exceeds 20 cents
   always_comb begin
      w_dime_need = 8'd0;
      if (w_change >= 8'd20)
         w_dime_need = 8'd2;
      else if (w_change >= 8'd10)
         w_dime_need = 8'd1;
      w_sub_dime = (w_dime_need > dimeCount) ? dimeCount : w_dime_need;
      w_rem = w_change - (w_sub_dime * 8'd10);
      w_nickel_need = 8'd0;
      if (w_rem >= 8'd20)
         w_nickel_need = 8'd4;
      else if (w_rem >= 8'd15)
         w_nickel_need = 8'd3;
      else if (w_rem >= 8'd10)
         w_nickel_need = 8'd2;
      else if (w_rem >= 8'd5)
         w_nickel_need = 8'd1;
      w_sub_nickel = (w_nickel_need > nickelCount) ? nickelCount : w_nickel_need;
      w_short = (w_rem != (w_sub_nickel * 8'd5));
   end

   // One-hot vend code indexed by change/5
   always_comb begin
      w_vend_code = 6'b000000;
      case (w_change)
         8'd0:    w_vend_code = 6'b000001;
         8'd5:    w_vend_code = 6'b000010;
         8'd10:   w_vend_code = 6'b000100;
         8'd15:   w_vend_code = 6'b001000;
         8'd20:   w_vend_code = 6'b010000;
         default: w_vend_code = 6'b000000;
      endcase
   end

   // FSM and registered outputs; pulses default low every cycle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_credit     <= 8'd0;
         r_count_en   <= 1'b0;
         r_coin_out   <= 2'b00;
         r_reject     <= 1'b0;
         r_dispense   <= 6'b000000;
         r_sub_nickel <= 8'd0;
         r_sub_dime   <= 8'd0;
         r_short      <= 1'b0;
`ifdef EXACT_CHANGE_EN
         r_exact      <= 1'b0;
`endif
      end else begin
         r_count_en   <= w_accept;
         r_coin_out   <= w_accept ? coin_in : 2'b00;
         r_reject     <= w_reject;
         r_dispense   <= 6'b000000;
         r_sub_nickel <= 8'd0;
         r_sub_dime   <= 8'd0;
         r_short      <= 1'b0;
`ifdef EXACT_CHANGE_EN
         r_exact      <= w_exact_next;
`endif
         case (r_state)
            ST_IDLE: begin
               if (w_paid) begin
                  r_state    <= ST_VEND;
                  r_dispense <= w_vend_code;
               end else if (w_accept) begin
                  r_credit <= w_sum[7:0];
               end
            end
            ST_VEND: begin
               r_state      <= ST_CHANGE;
               r_sub_dime   <= w_sub_dime;
               r_sub_nickel <= w_sub_nickel;
               r_short      <= w_short;
            end
            ST_CHANGE: begin
               r_state  <= ST_IDLE;
               r_credit <= 8'd0;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_credit <= 8'd0;
            end
         endcase
      end
   end

   assign countEnable   = r_count_en;
   assign coin_out      = r_coin_out;
   assign coinReject    = r_reject;
   assign credit        = r_credit;
   assign dispenseReady = r_dispense;
   assign subNickel     = r_sub_nickel;
   assign subDime       = r_sub_dime;
   assign changeShort   = r_short;
`ifdef EXACT_CHANGE_EN
   assign exactChange   = r_exact;
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - directed vector bench for change_dispenser
module tb_change_dispenser;

   logic       clock;
   logic       reset;
   logic [1:0] coin_in;
   logic       coin_valid;
   logic [7:0] nickelCount;
   logic [7:0] dimeCount;
   logic       countEnable;
   logic [1:0] coin_out;
   logic       coinReject;
   logic [7:0] credit;
   logic [5:0] dispenseReady;
   logic [7:0] subNickel;
   logic [7:0] subDime;
   logic       changeShort;
`ifdef EXACT_CHANGE_EN
   logic       exactChange;
`endif

   int checks;
   int failures;

   typedef struct {
      logic [1:0] coin;
      logic       valid;
      logic [7:0] nc;
      logic [7:0] dc;
      logic       ce;
      logic [1:0] co;
      logic       rej;
      logic [7:0] cr;
      logic [5:0] dr;
      logic [7:0] sn;
      logic [7:0] sd;
      logic       cs;
   } vec_t;

   vec_t vt[$];

   change_dispenser #(.PRICE(8'd65)) dut (
      .clock(clock),
      .reset(reset),
      .coin_in(coin_in),
      .coin_valid(coin_valid),
      .nickelCount(nickelCount),
      .dimeCount(dimeCount),
      .countEnable(countEnable),
      .coin_out(coin_out),
      .coinReject(coinReject),
      .credit(credit),
      .dispenseReady(dispenseReady),
      .subNickel(subNickel),
      .subDime(subDime),
      .changeShort(changeShort)
`ifdef EXACT_CHANGE_EN
      ,
      .exactChange(exactChange)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s row=%0d got=%0h expected=%0h", nm, idx, act, exp);
      end
   endtask

   task automatic add(input logic [1:0] coin, input logic valid, input logic [7:0] nc, input logic [7:0] dc,
                      input logic ce, input logic [1:0] co, input logic rej, input logic [7:0] cr,
                      input logic [5:0] dr, input logic [7:0] sn, input logic [7:0] sd, input logic cs);
      vec_t v;
      v.coin = coin; v.valid = valid; v.nc = nc; v.dc = dc;
      v.ce = ce; v.co = co; v.rej = rej; v.cr = cr;
      v.dr = dr; v.sn = sn; v.sd = sd; v.cs = cs;
      vt.push_back(v);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, " countEnable"}, -1, 32'(countEnable), 32'd0);
      chk({tag, " coin_out"}, -1, 32'(coin_out), 32'd0);
      chk({tag, " coinReject"}, -1, 32'(coinReject), 32'd0);
      chk({tag, " credit"}, -1, 32'(credit), 32'd0);
      chk({tag, " dispenseReady"}, -1, 32'(dispenseReady), 32'd0);
      chk({tag, " subNickel"}, -1, 32'(subNickel), 32'd0);
      chk({tag, " subDime"}, -1, 32'(subDime), 32'd0);
      chk({tag, " changeShort"}, -1, 32'(changeShort), 32'd0);
   endtask

   task automatic step(input logic [1:0] coin, input logic valid);
      @(negedge clock);
      coin_in    = coin;
      coin_valid = valid;
      @(posedge clock);
      #1;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      reset       = 1'b1;
      coin_in     = 2'b00;
      coin_valid  = 1'b0;
      nickelCount = 8'd5;
      dimeCount   = 8'd5;

      // coin, valid, N, D | ce, coin_out, rej, credit, dispense, subN, subD, short
      // Exact payment 25+25+10+5 = 65, with a null-coin strobe ignored
      add(2'b11, 1, 8'd5, 8'd5, 1, 2'b11, 0, 8'd25, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b00, 1, 8'd5, 8'd5, 0, 2'b00, 0, 8'd25, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b11, 1, 8'd5, 8'd5, 1, 2'b11, 0, 8'd50, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b10, 1, 8'd5, 8'd5, 1, 2'b10, 0, 8'd60, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b01, 1, 8'd5, 8'd5, 1, 2'b01, 0, 8'd65, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b00, 0, 8'd5, 8'd5, 0, 2'b00, 0, 8'd65, 6'b000001, 8'd0, 8'd0, 0);
      add(2'b00, 0, 8'd5, 8'd5, 0, 2'b00, 0, 8'd65, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b00, 0, 8'd5, 8'd5, 0, 2'b00, 0, 8'd0,  6'b000000, 8'd0, 8'd0, 0);
      // Three quarters, 10c change from a dime; dimes strobed at VEND entry and in VEND are refused
      add(2'b11, 1, 8'd1, 8'd3, 1, 2'b11, 0, 8'd25, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b11, 1, 8'd1, 8'd3, 1, 2'b11, 0, 8'd50, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b11, 1, 8'd1, 8'd3, 1, 2'b11, 0, 8'd75, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b10, 1, 8'd1, 8'd3, 0, 2'b00, 1, 8'd75, 6'b000100, 8'd0, 8'd0, 0);
      add(2'b10, 1, 8'd1, 8'd3, 0, 2'b00, 1, 8'd75, 6'b000000, 8'd0, 8'd1, 0);
      add(2'b00, 0, 8'd1, 8'd3, 0, 2'b00, 0, 8'd0,  6'b000000, 8'd0, 8'd0, 0);
      // 85c, 20c change: one dime plus two nickels
      add(2'b11, 1, 8'd5, 8'd1, 1, 2'b11, 0, 8'd25, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b11, 1, 8'd5, 8'd1, 1, 2'b11, 0, 8'd50, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b10, 1, 8'd5, 8'd1, 1, 2'b10, 0, 8'd60, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b11, 1, 8'd5, 8'd1, 1, 2'b11, 0, 8'd85, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b00, 0, 8'd5, 8'd1, 0, 2'b00, 0, 8'd85, 6'b010000, 8'd0, 8'd0, 0);
      add(2'b00, 0, 8'd5, 8'd1, 0, 2'b00, 0, 8'd85, 6'b000000, 8'd2, 8'd1, 0);
      add(2'b00, 0, 8'd5, 8'd1, 0, 2'b00, 0, 8'd0,  6'b000000, 8'd0, 8'd0, 0);
      // 85c with only one nickel: 15c shortfall forfeited
      add(2'b11, 1, 8'd1, 8'd0, 1, 2'b11, 0, 8'd25, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b11, 1, 8'd1, 8'd0, 1, 2'b11, 0, 8'd50, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b10, 1, 8'd1, 8'd0, 1, 2'b10, 0, 8'd60, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b11, 1, 8'd1, 8'd0, 1, 2'b11, 0, 8'd85, 6'b000000, 8'd0, 8'd0, 0);
      add(2'b00, 0, 8'd1, 8'd0, 0, 2'b00, 0, 8'd85, 6'b010000, 8'd0, 8'd0, 0);
      add(2'b00, 0, 8'd1, 8'd0, 0, 2'b00, 0, 8'd85, 6'b000000, 8'd1, 8'd0, 1);
      add(2'b00, 0, 8'd1, 8'd0, 0, 2'b00, 0, 8'd0,  6'b000000, 8'd0, 8'd0, 0);

      // Reset state
      #12;
      check_all_zero("reset");

      // Release reset and present the first coin in the same cycle
      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < vt.size(); i++) begin
         if (i != 0) @(negedge clock);
         coin_in     = vt[i].coin;
         coin_valid  = vt[i].valid;
         nickelCount = vt[i].nc;
         dimeCount   = vt[i].dc;
         @(posedge clock);
         #1;
         chk("countEnable", i, 32'(countEnable), 32'(vt[i].ce));
         chk("coin_out", i, 32'(coin_out), 32'(vt[i].co));
         chk("coinReject", i, 32'(coinReject), 32'(vt[i].rej));
         chk("credit", i, 32'(credit), 32'(vt[i].cr));
         chk("dispenseReady", i, 32'(dispenseReady), 32'(vt[i].dr));
         chk("subNickel", i, 32'(subNickel), 32'(vt[i].sn));
         chk("subDime", i, 32'(subDime), 32'(vt[i].sd));
         chk("changeShort", i, 32'(changeShort), 32'(vt[i].cs));
      end

      // Reset asserted in the middle of CHANGE clears everything immediately
      nickelCount = 8'd1;
      dimeCount   = 8'd3;
      step(2'b11, 1);
      step(2'b11, 1);
      step(2'b11, 1);
      step(2'b00, 0);
      chk("midchg vend code", -1, 32'(dispenseReady), 32'b000100);
      step(2'b00, 0);
      chk("midchg subDime before reset", -1, 32'(subDime), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("midchg");
      @(negedge clock);
      reset      = 1'b0;
      coin_in    = 2'b11;
      coin_valid = 1'b1;
      @(posedge clock);
      #1;
      chk("post-reset first coin credit", -1, 32'(credit), 32'd25);
      chk("post-reset first coin countEnable", -1, 32'(countEnable), 32'd1);
      chk("post-reset subDime", -1, 32'(subDime), 32'd0);

`ifdef EXACT_CHANGE_EN
      // No nickels: exact change required, overpaying quarter refused
      nickelCount = 8'd0;
      dimeCount   = 8'd5;
      step(2'b00, 0);
      chk("exactChange", -1, 32'(exactChange), 32'd1);
      step(2'b11, 1);
      chk("exact credit 50", -1, 32'(credit), 32'd50);
      step(2'b11, 1);
      chk("exact quarter reject", -1, 32'(coinReject), 32'd1);
      chk("exact quarter countEnable", -1, 32'(countEnable), 32'd0);
      chk("exact credit held", -1, 32'(credit), 32'd50);
      step(2'b10, 1);
      chk("exact dime accepted", -1, 32'(countEnable), 32'd1);
      chk("exact credit 60", -1, 32'(credit), 32'd60);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
